// File: rtl/seq_integer_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Define INTDIV_SIGNED_EN for two's-complement operands (magnitudes divided, signs fixed on entry to DONE).
module seq_integer_divider #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(M + 1);

`ifdef INTDIV_SIGNED_EN
  function automatic logic [M-1:0] abs_m(input logic [M-1:0] v);
    return v[M-1] ? -v : v;
  endfunction

  function automatic logic [N-1:0] abs_n(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  function automatic logic [M-1:0] sgn_m(input logic [M-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [N-1:0] sgn_n(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic negq_q, negq_d, negr_q, negr_d;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    part_q, part_d;
  logic [M-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          zdiv_q, zdiv_d;
  logic [M-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N+1:0]  sh;
  logic          ge;
  logic [N:0]    part_nx;
  logic [M-1:0]  dvd_nx;

  // One restoring step; dvd_q shifts dividend bits out and quotient bits in.
  always_comb begin
    sh      = {part_q, dvd_q[M-1]};
    ge      = (sh >= {2'b00, dvs_q});
    part_nx = ge ? (N+1)'(sh - {2'b00, dvs_q}) : (N+1)'(sh);
    dvd_nx  = {dvd_q[M-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zdiv_d  = zdiv_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef INTDIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          part_d  = '0;
          zdiv_d  = (divisor == '0);
`ifdef INTDIV_SIGNED_EN
          dvd_d  = abs_m(dividend);
          dvs_d  = abs_n(divisor);
          negq_d = dividend[M-1] ^ divisor[N-1];
          negr_d = dividend[M-1];
`else
          dvd_d  = dividend;
          dvs_d  = divisor;
`endif
          // A zero divisor spends a single idle slot so results land through the same DONE entry.
          if (divisor == '0) begin
            dvd_d = dividend;
            cnt_d = CW'(1);
          end else begin
            cnt_d = CW'(M);
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (!zdiv_q) begin
          part_d = part_nx;
          dvd_d  = dvd_nx;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dbz_d   = zdiv_q;
          if (zdiv_q) begin
            quot_d = '1;
            rem_d  = dvd_q[N-1:0];
          end else begin
`ifdef INTDIV_SIGNED_EN
            quot_d = sgn_m(dvd_nx, negq_q);
            rem_d  = sgn_n(part_nx[N-1:0], negr_q);
`else
            quot_d = dvd_nx;
            rem_d  = part_nx[N-1:0];
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zdiv_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef INTDIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zdiv_q  <= zdiv_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef INTDIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
